// File: rtl/rsa_job_arbiter_pkg.sv
// Shared definitions for the RSA job arbiter: default widths/limits and FSM state type.
package rsa_job_arbiter_pkg;

  localparam int unsigned RSA_BITS           = 32;
  localparam int unsigned RSA_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    RSA_ARB_IDLE,
    RSA_ARB_SETUP,
    RSA_ARB_RUN,
    RSA_ARB_DONE,
    RSA_ARB_ABORT
  } arb_state_e;

endpackage

// File: rtl/rsa_job_arbiter_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that did not own the engine last wins.
module rsa_rr_pick
  import rsa_job_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_owner;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Shares one RSA exponent engine between two requesters: RR grant, operand latch, GO sequencing.
// Optional RUN-state watchdog enabled by defining RSA_ARB_TIMEOUT_EN.
module rsa_job_arbiter
  import rsa_job_arbiter_pkg::*;
#(
  parameter int unsigned BITS           = RSA_BITS,
  parameter int unsigned TIMEOUT_CYCLES = RSA_TIMEOUT_CYCLES
) (
  input  logic            sysclk,
  input  logic            sysreset_n,
  input  logic            req0,
  input  logic            req1,
  input  logic [BITS-1:0] m0,
  input  logic [BITS-1:0] e0,
  input  logic [BITS-1:0] n0,
  input  logic [BITS-1:0] m1,
  input  logic [BITS-1:0] e1,
  input  logic [BITS-1:0] n1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [BITS-1:0] result,
  output logic            err,
  output logic            eng_go,
  output logic [BITS-1:0] eng_m,
  output logic [BITS-1:0] eng_e,
  output logic [BITS-1:0] eng_n,
  input  logic [BITS-1:0] eng_r,
  input  logic            eng_d,
  output logic            busy
);

  arb_state_e      state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_owner_q, last_owner_d;
  logic [BITS-1:0] eng_m_q, eng_m_d, eng_e_q, eng_e_d, eng_n_q, eng_n_d;
  logic [BITS-1:0] result_q, result_d;
  logic            err_q, err_d;
  logic            pick_valid, pick_winner, owner_req, timeout_hit;

  rsa_rr_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign owner_req = owner_q ? req1 : req0;

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts completed RUN cycles, so the limit hits on the TIMEOUT_CYCLES-th RUN cycle
  assign timeout_hit = (state_q == RSA_ARB_RUN) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RSA_ARB_SETUP) begin
      cnt_d = '0;
    end else if (state_q == RSA_ARB_RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    eng_m_d      = eng_m_q;
    eng_e_d      = eng_e_q;
    eng_n_d      = eng_n_q;
    result_d     = result_q;
    err_d        = err_q;
    case (state_q)
      RSA_ARB_IDLE: begin
        if (pick_valid) begin
          state_d      = RSA_ARB_SETUP;
          owner_d      = pick_winner;
          last_owner_d = pick_winner;
          eng_m_d      = pick_winner ? m1 : m0;
          eng_e_d      = pick_winner ? e1 : e0;
          eng_n_d      = pick_winner ? n1 : n0;
        end
      end
      RSA_ARB_SETUP: begin
        if (!owner_req) begin
          state_d = RSA_ARB_ABORT;
        end else if (eng_n_q < BITS'(2)) begin
          state_d  = RSA_ARB_DONE;
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          state_d = RSA_ARB_RUN;
        end
      end
      RSA_ARB_RUN: begin
        // abort takes priority over a same-cycle engine completion
        if (!owner_req) begin
          state_d = RSA_ARB_ABORT;
        end else if (eng_d) begin
          state_d  = RSA_ARB_DONE;
          result_d = eng_r;
          err_d    = 1'b0;
        end else if (timeout_hit) begin
          state_d  = RSA_ARB_DONE;
          result_d = '0;
          err_d    = 1'b1;
        end
      end
      RSA_ARB_DONE:  state_d = RSA_ARB_IDLE;
      RSA_ARB_ABORT: state_d = RSA_ARB_IDLE;
      default:       state_d = RSA_ARB_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q      <= RSA_ARB_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      eng_m_q      <= '0;
      eng_e_q      <= '0;
      eng_n_q      <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      eng_m_q      <= eng_m_d;
      eng_e_q      <= eng_e_d;
      eng_n_q      <= eng_n_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    done0  = 1'b0;
    done1  = 1'b0;
    if (state_q == RSA_ARB_SETUP || state_q == RSA_ARB_RUN || state_q == RSA_ARB_DONE) begin
      gnt0 = ~owner_q;
      gnt1 = owner_q;
    end
    if (state_q == RSA_ARB_DONE) begin
      done0 = ~owner_q;
      done1 = owner_q;
    end
    eng_go = (state_q == RSA_ARB_RUN);
    busy   = (state_q != RSA_ARB_IDLE);
  end

  assign eng_m  = eng_m_q;
  assign eng_e  = eng_e_q;
  assign eng_n  = eng_n_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Scoreboard bench for rsa_job_arbiter with a behavioural modexp engine (d rises ENG_LAT cycles after go).
module tb_rsa_job_arbiter;

  localparam int unsigned BITS    = 32;
  localparam int unsigned TO      = 16;
  localparam int unsigned ENG_LAT = 5;

  logic            sysclk, sysreset_n;
  logic            req0, req1;
  logic [BITS-1:0] m0, e0, n0, m1, e1, n1;
  logic            gnt0, gnt1, done0, done1, err, eng_go, eng_d, busy;
  logic [BITS-1:0] result, eng_m, eng_e, eng_n, eng_r;

  rsa_job_arbiter #(.BITS(BITS), .TIMEOUT_CYCLES(TO)) dut (
    .sysclk(sysclk), .sysreset_n(sysreset_n),
    .req0(req0), .req1(req1),
    .m0(m0), .e0(e0), .n0(n0), .m1(m1), .e1(e1), .n1(n1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .err(err), .eng_go(eng_go),
    .eng_m(eng_m), .eng_e(eng_e), .eng_n(eng_n),
    .eng_r(eng_r), .eng_d(eng_d), .busy(busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic logic [BITS-1:0] modexp(input logic [BITS-1:0] m, e, n);
    longint unsigned r, b, md;
    if (n == '0) return '0;
    md = longint'(n);
    r  = 1 % md;
    b  = longint'(m) % md;
    for (int i = 0; i < int'(BITS); i++) begin
      if (e[i]) r = (r * b) % md;
      b = (b * b) % md;
    end
    return BITS'(r);
  endfunction

  logic [7:0]  eng_cnt = '0;
  bit          eng_stall = 1'b0;
  int unsigned go_cycles = 0;

  always @(posedge sysclk) begin
    if (!eng_go) eng_cnt <= '0;
    else if (eng_cnt != 8'hff) eng_cnt <= eng_cnt + 8'd1;
    if (eng_go) go_cycles <= go_cycles + 1;
  end
  assign eng_d = eng_go && !eng_stall && (eng_cnt >= 8'(ENG_LAT));
  assign eng_r = modexp(eng_m, eng_e, eng_n);

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit              owner;
    logic [BITS-1:0] result;
    bit              err;
  } exp_t;
  exp_t sb[$];

  always @(negedge sysclk) begin
    exp_t e;
    if (sysreset_n && (done0 || done1)) begin
      check("done_excl", 64'(done0 & done1), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("done_owner", 64'(done1), 64'(e.owner));
        check("done_result", 64'(result), 64'(e.result));
        check("done_err", 64'(err), 64'(e.err));
      end
    end
  end

  // sel: 0 = done0, 1 = done1, 2 = eng_go; returns at the negedge where it is seen high
  task automatic wait_for(input int sel, input string tag);
    int  n = 0;
    bit  hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge sysclk);
      n++;
      case (sel)
        0:       hit = done0;
        1:       hit = done1;
        default: hit = eng_go;
      endcase
    end
    if (!hit) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    sysreset_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge sysclk);
    sysreset_n = 1'b1;
    @(negedge sysclk);
  endtask

  int unsigned g;

  initial begin
    sysreset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    m0 = '0; e0 = '0; n0 = '0; m1 = '0; e1 = '0; n1 = '0;
    repeat (3) @(negedge sysclk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gnt", 64'({gnt1, gnt0}), 64'd0);
    check("rst_done", 64'({done1, done0}), 64'd0);
    check("rst_go", 64'(eng_go), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_eng_n", 64'(eng_n), 64'd0);
    sysreset_n = 1'b1;
    @(negedge sysclk);

    // single job from requester 0, latency checks
    req0 = 1'b1; m0 = 7; e0 = 3; n0 = 33;
    sb.push_back('{owner: 1'b0, result: 32'd13, err: 1'b0});
    @(negedge sysclk);
    check("a_gnt0_t1", 64'(gnt0), 64'd1);
    check("a_gnt1_t1", 64'(gnt1), 64'd0);
    check("a_go_t1", 64'(eng_go), 64'd0);
    @(negedge sysclk);
    check("a_go_t2", 64'(eng_go), 64'd1);
    check("a_eng_m", 64'(eng_m), 64'd7);
    check("a_eng_n", 64'(eng_n), 64'd33);
    wait_for(0, "a_done");
    check("a_gnt0_done", 64'(gnt0), 64'd1);
    check("a_go_done", 64'(eng_go), 64'd0);
    req0 = 1'b0;
    repeat (2) @(negedge sysclk);
    check("a_busy_after", 64'(busy), 64'd0);
    check("a_gnt0_after", 64'(gnt0), 64'd0);

    // simultaneous requests right after reset: req0 wins, then req1
    do_reset();
    req0 = 1'b1; m0 = 7; e0 = 3; n0 = 33;
    req1 = 1'b1; m1 = 2; e1 = 10; n1 = 1000;
    sb.push_back('{owner: 1'b0, result: 32'd13, err: 1'b0});
    sb.push_back('{owner: 1'b1, result: 32'd24, err: 1'b0});
    @(negedge sysclk);
    check("b_first_gnt", 64'({gnt1, gnt0}), 64'd1);
    wait_for(0, "b_done0");
    check("b_gnt1_idle", 64'(gnt1), 64'd0);
    req0 = 1'b0;
    wait_for(1, "b_done1");
    check("b_gnt1_done", 64'(gnt1), 64'd1);
    check("b_eng_m1", 64'(eng_m), 64'd2);
    req1 = 1'b0;
    repeat (2) @(negedge sysclk);

    // requester 1 drops its request mid-RUN
    req1 = 1'b1; m1 = 3; e1 = 4; n1 = 77;
    wait_for(2, "c_go");
    @(negedge sysclk);
    req1 = 1'b0;
    @(negedge sysclk);
    check("c_abort_go", 64'(eng_go), 64'd0);
    check("c_abort_busy", 64'(busy), 64'd1);
    check("c_abort_done1", 64'(done1), 64'd0);
    @(negedge sysclk);
    check("c_busy_after", 64'(busy), 64'd0);
    check("c_result_kept", 64'(result), 64'd24);
    check("c_err_kept", 64'(err), 64'd0);

    // modulus below 2 is rejected without starting the engine
    req0 = 1'b1; m0 = 5; e0 = 3; n0 = 1;
    sb.push_back('{owner: 1'b0, result: 32'd0, err: 1'b1});
    g = go_cycles;
    wait_for(0, "d_done");
    req0 = 1'b0;
    check("d_go_never", 64'(go_cycles - g), 64'd0);
    repeat (2) @(negedge sysclk);

    // asynchronous reset during RUN, then the held request is served again
    req0 = 1'b1; m0 = 7; e0 = 3; n0 = 33;
    wait_for(2, "e_go");
    #2 sysreset_n = 1'b0;
    #1;
    check("e_rst_go", 64'(eng_go), 64'd0);
    check("e_rst_gnt0", 64'(gnt0), 64'd0);
    check("e_rst_busy", 64'(busy), 64'd0);
    check("e_rst_err", 64'(err), 64'd0);
    check("e_rst_eng_m", 64'(eng_m), 64'd0);
    @(negedge sysclk);
    sysreset_n = 1'b1;
    sb.push_back('{owner: 1'b0, result: 32'd13, err: 1'b0});
    wait_for(0, "e_done");
    req0 = 1'b0;
    repeat (2) @(negedge sysclk);

`ifdef RSA_ARB_TIMEOUT_EN
    // stalled engine: watchdog ends the job after TO RUN cycles
    eng_stall = 1'b1;
    req1 = 1'b1; m1 = 9; e1 = 9; n1 = 99;
    sb.push_back('{owner: 1'b1, result: 32'd0, err: 1'b1});
    g = go_cycles;
    wait_for(1, "f_done");
    req1 = 1'b0;
    check("f_run_cycles", 64'(go_cycles - g), 64'(TO));
    eng_stall = 1'b0;
    repeat (2) @(negedge sysclk);
`endif

    repeat (2) @(negedge sysclk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
